// File: rtl/lc3_disp_pkg.sv
// Shared constants for the LC3 front-panel register display.
// Register-select codes, 7-segment encodings and the blank pattern.
package lc3_disp_pkg;

    localparam logic [3:0] REG_R0  = 4'd0;
    localparam logic [3:0] REG_R1  = 4'd1;
    localparam logic [3:0] REG_R2  = 4'd2;
    localparam logic [3:0] REG_R3  = 4'd3;
    localparam logic [3:0] REG_R4  = 4'd4;
    localparam logic [3:0] REG_R5  = 4'd5;
    localparam logic [3:0] REG_R6  = 4'd6;
    localparam logic [3:0] REG_R7  = 4'd7;
    localparam logic [3:0] REG_PC  = 4'd8;
    localparam logic [3:0] REG_MAR = 4'd9;
    localparam logic [3:0] REG_MDR = 4'd10;
    localparam logic [3:0] REG_IR  = 4'd11;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segments, dp (bit 7) held off.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lc3_btn_debounce.sv
// Push-button synchronizer and debouncer.
// Emits a single-cycle pulse on each accepted press.
module lc3_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                        $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          flip;

    always_comb begin
        flip    = 1'b0;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (flip) begin
            level_d = ~level_q;
        end
        rise_d = flip & ~level_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/lc3_reg_display.sv
// LC3 register viewer: button-stepped select, 4-digit multiplexed hex display.
// Optional: define LC3_DISP_LEADING_BLANK_EN to blank leading zero digits.
module lc3_reg_display
    import lc3_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REFRESH_DIV     = 2,
    parameter int NUM_REGS        = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [15:0] view_data,
    output logic [3:0]  sel,
    output logic [7:0]  seg_output_single,
    output logic [3:0]  seg_output_sequence,
    output logic [3:0]  led_output
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(REFRESH_DIV - 1);
    localparam logic [3:0]    SEL_MAX  = 4'(NUM_REGS - 1);

    logic          step;
    logic [3:0]    sel_q, sel_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   frame_q, frame_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    nib;
    logic          blank;

    lc3_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i (clk),
        .rst_i (rst),
        .btn_i (btn),
        .rise_o(step)
    );

    always_comb begin
        sel_d = sel_q;
        if (step) begin
            sel_d = (sel_q == SEL_MAX) ? REG_R0 : sel_q + 4'd1;
        end
    end

    // Frame is sampled only at the 3->0 wrap so a frame never tears.
    always_comb begin
        scan_d  = scan_q + 1'b1;
        digit_d = digit_q;
        frame_d = frame_q;
        if (scan_q == SCAN_MAX) begin
            scan_d  = '0;
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
                frame_d = view_data;
            end
        end
    end

    always_comb begin
        nib   = frame_q[3:0];
        blank = 1'b0;
        case (digit_q)
            2'd0: nib = frame_q[3:0];
            2'd1: nib = frame_q[7:4];
            2'd2: nib = frame_q[11:8];
            default: nib = frame_q[15:12];
        endcase
`ifdef LC3_DISP_LEADING_BLANK_EN
        case (digit_q)
            2'd1: blank = (frame_q[15:4] == 12'h000);
            2'd2: blank = (frame_q[15:8] == 8'h00);
            2'd3: blank = (frame_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
        seg_d = blank ? SEG_BLANK : seg_encode(nib);
        an_d  = ~(4'b0001 << digit_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= REG_R0;
            scan_q  <= '0;
            digit_q <= 2'd0;
            frame_q <= 16'h0000;
            seg_q   <= 8'hC0;
            an_q    <= 4'b1110;
        end else begin
            sel_q   <= sel_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign sel                 = sel_q;
    assign led_output          = sel_q;
    assign seg_output_single   = seg_q;
    assign seg_output_sequence = an_q;

endmodule

// File: tb/tb_lc3_reg_display.sv
// Directed bench for lc3_reg_display (DEBOUNCE_CYCLES=4, REFRESH_DIV=2).
module tb_lc3_reg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic [15:0] view_data = 16'h1234;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [3:0]  led;

    int n_assert = 0;
    int n_fail   = 0;

    lc3_reg_display #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_DIV    (2),
        .NUM_REGS       (12)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .btn                (btn),
        .view_data          (view_data),
        .sel                (sel),
        .seg_output_single  (seg),
        .seg_output_sequence(an),
        .led_output         (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] pat);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === pat) found = 1'b1;
        end
        check("wait_digit", {15'd0, found}, 16'd1);
    endtask

    task automatic frame_start();
        wait_an(4'b0111);
        wait_an(4'b1110);
    endtask

    task automatic press();
        @(posedge clk); #1 btn = 1'b1;
        repeat (10) @(posedge clk);
        #1 btn = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #12;
        @(negedge clk);
        check("rst_sel", {12'd0, sel}, 16'h0);
        check("rst_led", {12'd0, led}, 16'h0);
        check("rst_an", {12'd0, an}, 16'hE);
        check("rst_seg", {8'd0, seg}, 16'hC0);
        rst = 1'b0;

        // 1234 frame, digit 0 held two cycles
        frame_start();
        check("f1234_d0", {8'd0, seg}, 16'h99);
        @(negedge clk);
        check("hold_d0", {12'd0, an}, 16'hE);
        @(negedge clk);
        check("adv_d1", {12'd0, an}, 16'hD);
        check("f1234_d1", {8'd0, seg}, 16'hB0);
        wait_an(4'b1011);
        check("f1234_d2", {8'd0, seg}, 16'hA4);
        wait_an(4'b0111);
        check("f1234_d3", {8'd0, seg}, 16'hF9);

        // short glitch rejected
        @(posedge clk); #1 btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_sel", {12'd0, sel}, 16'h0);

        // clean press held 10 cycles
        @(posedge clk); #1 btn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("press_sel", {12'd0, sel}, 16'h1);
        check("press_led", {12'd0, led}, 16'h1);
        #1 btn = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("release_sel", {12'd0, sel}, 16'h1);

        for (int k = 2; k <= 12; k++) begin
            press();
            check("step_sel", {12'd0, sel}, 16'(k % 12));
            check("step_led", {12'd0, led}, 16'(k % 12));
        end

        // coherent frame under data change
        view_data = 16'hAAAA;
        frame_start();
        check("tear_d0", {8'd0, seg}, 16'h88);
        wait_an(4'b1101);
        check("tear_d1", {8'd0, seg}, 16'h88);
        view_data = 16'h5555;
        wait_an(4'b1011);
        check("tear_d2", {8'd0, seg}, 16'h88);
        wait_an(4'b0111);
        check("tear_d3", {8'd0, seg}, 16'h88);
        wait_an(4'b1110);
        check("new_d0", {8'd0, seg}, 16'h92);
        wait_an(4'b1101);
        check("new_d1", {8'd0, seg}, 16'h92);

        // async reset mid-frame with sel = 7
        repeat (7) press();
        check("sel7", {12'd0, sel}, 16'h7);
        wait_an(4'b1011);
        #2 rst = 1'b1;
        #1;
        check("arst_sel", {12'd0, sel}, 16'h0);
        check("arst_led", {12'd0, led}, 16'h0);
        check("arst_an", {12'd0, an}, 16'hE);
        check("arst_seg", {8'd0, seg}, 16'hC0);

        // leading zeros
        view_data = 16'h00F0;
        @(negedge clk);
        rst = 1'b0;
        frame_start();
        check("lz_d0", {8'd0, seg}, 16'hC0);
        wait_an(4'b1101);
        check("lz_d1", {8'd0, seg}, 16'h8E);
        wait_an(4'b1011);
`ifdef LC3_DISP_LEADING_BLANK_EN
        check("lz_d2", {8'd0, seg}, 16'hFF);
        wait_an(4'b0111);
        check("lz_d3", {8'd0, seg}, 16'hFF);
`else
        check("lz_d2", {8'd0, seg}, 16'hC0);
        wait_an(4'b0111);
        check("lz_d3", {8'd0, seg}, 16'hC0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
